multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Main control FSM of the multicycle RV32I core; drives the select codes consumed by the datapath source muxes (ALU A/B source, result source, PC source) and all write enables.
- Sequences each instruction through fetch, decode, execute, memory and writeback, stalling on a valid/ready memory handshake.
- Sits between the instruction register fields and the datapath; the ALU operation code comes from one combinational sub-decoder.

Parameters:
- RESET_TRAP, 0, 1 = an illegal opcode halts the core until reset; 0 = an illegal opcode is treated as a NOP (back to FETCH).

Ports:
- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous active-low reset
- opcode  in  7  instruction register bits [6:0]
- funct3  in  3  instruction register bits [14:12]
- funct7_5  in  1  instruction register bit 30
- mem_ready  in  1  memory completes the current request this cycle
- alu_zero, alu_lt, alu_ltu  in  1 each  ALU flags for the current cycle's operation
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a store
- mem_addr_src  out  1  0 = PC, 1 = alu_out buffer
- ir_we, pc_buf_we, rd_buf_we  out  1 each  load the IR, the PC buffer, and the rd1/rd2 buffers
- pc_we  out  1  PC write
- pc_src  out  1  0 = ALU result, 1 = alu_out buffer
- rf_we  out  1  register file write
- result_src  out  2  0 = ALU, 1 = mem data buffer, 2 = alu_out buffer
- alu_a_src  out  3  0 = PC, 1 = PC_BUF, 2 = RD1, 3 = RD1_BUF, 4 = ZERO
- alu_b_src  out  3  0 = RD2, 1 = RD2_BUF, 2 = IMM, 3 = FOUR, 4 = ZERO
- alu_ctrl  out  4  ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9
- halted  out  1  core stopped on an illegal opcode

Behaviour:
- Moore FSM plus mem_ready gating. All outputs are combinational from state and inputs. Unlisted enables are 0. Unlisted selects are A = PC, B = FOUR, ctrl = ADD.
- Reset (rstn low):
  - state = FETCH, halted = 0.
  - While rstn is low, mem_req and every *_we output are forced to 0. Selects show the FETCH values.
- FETCH:
  - mem_req = 1, mem_addr_src = 0.
  - When mem_ready = 1: ir_we = 1, pc_buf_we = 1, pc_we = 1 (PC <= PC + 4 via A = PC, B = FOUR), then go to DECODE.
  - When mem_ready = 0: hold, with no enables.
- DECODE:
  - rd_buf_we = 1; A = PC_BUF, B = IMM, ADD (branch/JAL target into alu_out).
  - Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 and 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - anything else -> TRAP
- EXEC_R: A = RD1_BUF, B = RD2_BUF, ctrl from the decoder, then ALU_WB.
- EXEC_I: A = RD1_BUF, B = IMM, then ALU_WB. funct7_5 is honoured only for funct3 = 101 (SRAI).
- LUI: A = ZERO, B = IMM, then ALU_WB.
- AUIPC: A = PC_BUF, B = IMM, then ALU_WB.
- ALU_WB: rf_we = 1, result_src = 2, then FETCH.
- MEM_ADDR: A = RD1_BUF, B = IMM, ADD; then MEM_RD if opcode = 0000011, else MEM_WR.
- MEM_RD: mem_req = 1, mem_addr_src = 1; wait for mem_ready, then MEM_WB.
- MEM_WB: rf_we = 1, result_src = 1, then FETCH.
- MEM_WR: mem_req = 1, mem_we = 1, mem_addr_src = 1; wait for mem_ready, then FETCH.
- BRANCH:
  - A = RD1_BUF, B = RD2_BUF, SUB; pc_src = 1; then FETCH.
  - pc_we = 1 when the condition holds:
    - BEQ: zero
    - BNE: !zero
    - BLT: lt
    - BGE: !lt
    - BLTU: ltu
    - BGEU: !ltu
  - funct3 010/011 is never taken.
- JAL: A = PC_BUF, B = FOUR, ADD; rf_we = 1, result_src = 0; pc_we = 1, pc_src = 1; then FETCH.
- JALR: A = RD1_BUF, B = IMM, ADD (target into alu_out), then JALR_WB.
- JALR_WB: same outputs as JAL; the datapath clears the target LSB. Then FETCH.
- TRAP:
  - If RESET_TRAP = 1: halted = 1, no enables, stay in TRAP until reset.
  - Otherwise: go straight to FETCH.
- Memory handshake:
  - mem_req stays high and mem_addr_src stays stable until mem_ready is seen.
  - The request completes in the cycle in which mem_req and mem_ready are both high.
  - mem_ready while mem_req = 0 is ignored.
- Reset mid-request drops mem_req asynchronously. No partial writeback occurs.

Decomposition:
- Shared include constants: ALU_A_SRC_*, ALU_B_SRC_*, RESULT_SRC_*, ALU_CTRL_*, OPCODE_*, FSM state codes (4-bit).
- Sub-module alu_ctrl_dec: combinational; inputs class (ADD / SUB / FUNCT), funct3, funct7_5, is_rtype; output alu_ctrl.

Test Plan:
- Reset released, mem_ready low for 3 cycles -> mem_req held for 4 cycles; ir_we/pc_we pulse only in the 4th cycle; next state DECODE.
- R-type SUB (opcode 0110011, funct3 000, funct7_5 1), mem_ready = 1 -> FETCH, DECODE, EXEC_R (A = 3, B = 1, ctrl = 1), ALU_WB (rf_we = 1, result_src = 2): 4 cycles.
- Load with 2 wait states -> MEM_RD holds mem_req = 1, mem_addr_src = 1 for 3 cycles; then MEM_WB with rf_we = 1, result_src = 1.
- BNE, alu_zero = 1 -> pc_we = 0. BNE, alu_zero = 0 -> pc_we = 1, pc_src = 1. BGEU, alu_ltu = 0 -> pc_we = 1.
- JALR -> JALR then JALR_WB; JALR_WB shows A = 1, B = 3, rf_we = 1, pc_we = 1, pc_src = 1.
- Opcode 0000000 with RESET_TRAP = 1 -> halted = 1 and no enables for 10 cycles. Then rstn low mid-MEM_WR -> mem_req drops within the same cycle; after release, state is FETCH and halted = 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: mux selects, ALU ops, opcodes, state codes.
package multicycle_ctrl_pkg;

    localparam int unsigned STATE_W    = 4;
    localparam int unsigned SRC_W      = 3;
    localparam int unsigned RES_W      = 2;
    localparam int unsigned ALU_CTRL_W = 4;
    localparam int unsigned OPCODE_W   = 7;

    // Datapath encodings RD1 = 2 (A), RD2 = 0 and ZERO = 4 (B) exist but are never selected here
    localparam logic [SRC_W-1:0] ALU_A_SRC_PC      = 3'd0;
    localparam logic [SRC_W-1:0] ALU_A_SRC_PC_BUF  = 3'd1;
    localparam logic [SRC_W-1:0] ALU_A_SRC_RD1_BUF = 3'd3;
    localparam logic [SRC_W-1:0] ALU_A_SRC_ZERO    = 3'd4;

    localparam logic [SRC_W-1:0] ALU_B_SRC_RD2_BUF = 3'd1;
    localparam logic [SRC_W-1:0] ALU_B_SRC_IMM     = 3'd2;
    localparam logic [SRC_W-1:0] ALU_B_SRC_FOUR    = 3'd3;

    localparam logic [RES_W-1:0] RESULT_SRC_ALU     = 2'd0;
    localparam logic [RES_W-1:0] RESULT_SRC_MEM     = 2'd1;
    localparam logic [RES_W-1:0] RESULT_SRC_ALU_OUT = 2'd2;

    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_ADD  = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SUB  = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SLL  = 4'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SLT  = 4'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SLTU = 4'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_XOR  = 4'd5;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SRL  = 4'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SRA  = 4'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_OR   = 4'd8;
    localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_AND  = 4'd9;

    localparam logic [OPCODE_W-1:0] OPCODE_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPCODE_AUIPC  = 7'b0010111;

    localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
    localparam logic [STATE_W-1:0] S_EXEC_R   = 4'd2;
    localparam logic [STATE_W-1:0] S_EXEC_I   = 4'd3;
    localparam logic [STATE_W-1:0] S_ALU_WB   = 4'd4;
    localparam logic [STATE_W-1:0] S_MEM_ADDR = 4'd5;
    localparam logic [STATE_W-1:0] S_MEM_RD   = 4'd6;
    localparam logic [STATE_W-1:0] S_MEM_WB   = 4'd7;
    localparam logic [STATE_W-1:0] S_MEM_WR   = 4'd8;
    localparam logic [STATE_W-1:0] S_BRANCH   = 4'd9;
    localparam logic [STATE_W-1:0] S_JAL      = 4'd10;
    localparam logic [STATE_W-1:0] S_JALR     = 4'd11;
    localparam logic [STATE_W-1:0] S_JALR_WB  = 4'd12;
    localparam logic [STATE_W-1:0] S_LUI      = 4'd13;
    localparam logic [STATE_W-1:0] S_AUIPC    = 4'd14;
    localparam logic [STATE_W-1:0] S_TRAP     = 4'd15;

    typedef enum logic [1:0] {
        ALU_CLASS_ADD   = 2'd0,
        ALU_CLASS_SUB   = 2'd1,
        ALU_CLASS_FUNCT = 2'd2
    } alu_class_e;

    // Branch condition from the SUB flags; funct3 010/011 are not branches
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt, input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_ctrl_dec.sv
// ALU operation decoder: fixed ADD/SUB for address and compare steps, funct-driven for R/I ops.
module alu_ctrl_dec
    import multicycle_ctrl_pkg::*;
(
    input  alu_class_e                  alu_class,
    input  logic [2:0]                  funct3,
    input  logic                        funct7_5,
    input  logic                        is_rtype,
    output logic [ALU_CTRL_W-1:0]       alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_CTRL_ADD;
        case (alu_class)
            ALU_CLASS_SUB: alu_ctrl = ALU_CTRL_SUB;
            ALU_CLASS_FUNCT: begin
                case (funct3)
                    // funct7_5 selects SUB only for R-type; ADDI ignores it
                    3'b000:  alu_ctrl = (is_rtype && funct7_5) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
                    3'b001:  alu_ctrl = ALU_CTRL_SLL;
                    3'b010:  alu_ctrl = ALU_CTRL_SLT;
                    3'b011:  alu_ctrl = ALU_CTRL_SLTU;
                    3'b100:  alu_ctrl = ALU_CTRL_XOR;
                    3'b101:  alu_ctrl = funct7_5 ? ALU_CTRL_SRA : ALU_CTRL_SRL;
                    3'b110:  alu_ctrl = ALU_CTRL_OR;
                    default: alu_ctrl = ALU_CTRL_AND;
                endcase
            end
            default: alu_ctrl = ALU_CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: fetch/decode/execute/memory/writeback sequencing
// with a valid/ready memory stall. Outputs are combinational; enables are forced low in reset.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter bit RESET_TRAP = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  mem_ready,
    input  logic                  alu_zero,
    input  logic                  alu_lt,
    input  logic                  alu_ltu,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_addr_src,
    output logic                  ir_we,
    output logic                  pc_buf_we,
    output logic                  rd_buf_we,
    output logic                  pc_we,
    output logic                  pc_src,
    output logic                  rf_we,
    output logic [RES_W-1:0]      result_src,
    output logic [SRC_W-1:0]      alu_a_src,
    output logic [SRC_W-1:0]      alu_b_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  halted
);

    logic [STATE_W-1:0] state, state_nxt;
    alu_class_e         alu_class;
    logic               is_rtype;
    logic               req_ung, we_ung, ir_we_ung, pc_buf_we_ung;
    logic               rd_buf_we_ung, pc_we_ung, rf_we_ung;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next state and per-state controls; selects default to the PC + 4 path
    always_comb begin
        state_nxt     = state;
        req_ung       = 1'b0;
        we_ung        = 1'b0;
        ir_we_ung     = 1'b0;
        pc_buf_we_ung = 1'b0;
        rd_buf_we_ung = 1'b0;
        pc_we_ung     = 1'b0;
        rf_we_ung     = 1'b0;
        mem_addr_src  = 1'b0;
        pc_src        = 1'b0;
        result_src    = RESULT_SRC_ALU;
        alu_a_src     = ALU_A_SRC_PC;
        alu_b_src     = ALU_B_SRC_FOUR;
        alu_class     = ALU_CLASS_ADD;
        is_rtype      = 1'b0;
        case (state)
            S_FETCH: begin
                req_ung = 1'b1;
                if (mem_ready) begin
                    ir_we_ung     = 1'b1;
                    pc_buf_we_ung = 1'b1;
                    pc_we_ung     = 1'b1;
                    state_nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                rd_buf_we_ung = 1'b1;
                alu_a_src     = ALU_A_SRC_PC_BUF;
                alu_b_src     = ALU_B_SRC_IMM;
                case (opcode)
                    OPCODE_OP:                 state_nxt = S_EXEC_R;
                    OPCODE_OP_IMM:             state_nxt = S_EXEC_I;
                    OPCODE_LOAD, OPCODE_STORE: state_nxt = S_MEM_ADDR;
                    OPCODE_BRANCH:             state_nxt = S_BRANCH;
                    OPCODE_JAL:                state_nxt = S_JAL;
                    OPCODE_JALR:               state_nxt = S_JALR;
                    OPCODE_LUI:                state_nxt = S_LUI;
                    OPCODE_AUIPC:              state_nxt = S_AUIPC;
                    default:                   state_nxt = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_a_src = ALU_A_SRC_RD1_BUF;
                alu_b_src = ALU_B_SRC_RD2_BUF;
                alu_class = ALU_CLASS_FUNCT;
                is_rtype  = 1'b1;
                state_nxt = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_a_src = ALU_A_SRC_RD1_BUF;
                alu_b_src = ALU_B_SRC_IMM;
                alu_class = ALU_CLASS_FUNCT;
                state_nxt = S_ALU_WB;
            end
            S_LUI: begin
                alu_a_src = ALU_A_SRC_ZERO;
                alu_b_src = ALU_B_SRC_IMM;
                state_nxt = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_a_src = ALU_A_SRC_PC_BUF;
                alu_b_src = ALU_B_SRC_IMM;
                state_nxt = S_ALU_WB;
            end
            S_ALU_WB: begin
                rf_we_ung  = 1'b1;
                result_src = RESULT_SRC_ALU_OUT;
                state_nxt  = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_a_src = ALU_A_SRC_RD1_BUF;
                alu_b_src = ALU_B_SRC_IMM;
                state_nxt = (opcode == OPCODE_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                req_ung      = 1'b1;
                mem_addr_src = 1'b1;
                if (mem_ready) state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                rf_we_ung  = 1'b1;
                result_src = RESULT_SRC_MEM;
                state_nxt  = S_FETCH;
            end
            S_MEM_WR: begin
                req_ung      = 1'b1;
                we_ung       = 1'b1;
                mem_addr_src = 1'b1;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                alu_a_src = ALU_A_SRC_RD1_BUF;
                alu_b_src = ALU_B_SRC_RD2_BUF;
                alu_class = ALU_CLASS_SUB;
                pc_src    = 1'b1;
                pc_we_ung = branch_taken(funct3, alu_zero, alu_lt, alu_ltu);
                state_nxt = S_FETCH;
            end
            S_JAL, S_JALR_WB: begin
                alu_a_src  = ALU_A_SRC_PC_BUF;
                alu_b_src  = ALU_B_SRC_FOUR;
                rf_we_ung  = 1'b1;
                result_src = RESULT_SRC_ALU;
                pc_we_ung  = 1'b1;
                pc_src     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JALR: begin
                alu_a_src = ALU_A_SRC_RD1_BUF;
                alu_b_src = ALU_B_SRC_IMM;
                state_nxt = S_JALR_WB;
            end
            S_TRAP: begin
                if (!RESET_TRAP) state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Request and enables drop immediately when reset asserts, even mid-request
    assign mem_req   = rstn && req_ung;
    assign mem_we    = rstn && we_ung;
    assign ir_we     = rstn && ir_we_ung;
    assign pc_buf_we = rstn && pc_buf_we_ung;
    assign rd_buf_we = rstn && rd_buf_we_ung;
    assign pc_we     = rstn && pc_we_ung;
    assign rf_we     = rstn && rf_we_ung;
    assign halted    = RESET_TRAP && (state == S_TRAP);

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_class (alu_class),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .is_rtype  (is_rtype),
        .alu_ctrl  (alu_ctrl)
    );

endmodule
